// File: rtl/dpram_burst_reader.sv
// Burst read client for a dual-port RAM port: streams a run of consecutive
// words out on a valid/ready interface, tagging the final word with out_last.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : start pulse, sampled only while busy=0
//   base_addr, num_words  : burst origin and length (0..NUM_WORDS)
//   busy, done            : burst in progress / one-cycle completion pulse
//   ram_address, ram_wren, ram_data, ram_out : RAM port (read-only use)
//   out_data, out_valid, out_ready, out_last : downstream stream
module dpram_burst_reader #(
  parameter int AWIDTH    = 11,
  parameter int NUM_WORDS = 2048,
  parameter int DWIDTH    = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_address,
  output logic              ram_wren,
  output logic [DWIDTH-1:0] ram_data,
  input  logic [DWIDTH-1:0] ram_out,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [AWIDTH:0]   remaining;
  logic              inflight;
  logic              inflight_last;
  logic [DWIDTH-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic              head_last;
  logic [1:0]        occ;
  logic [AWIDTH-1:0] addr_inc;

  // ram_address always presents the next address of the burst; a read
  // counts as issued in the cycle it is accepted, and its word is on
  // ram_out the following cycle.  Presenting an address that is not yet
  // accepted is harmless because reads have no side effects.
  assign ram_wren  = 1'b0;
  assign ram_data  = '0;
  assign out_valid = (count != 2'd0);
  assign head_last = fifo_last[rd_ptr];
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last  = out_valid & head_last;
  assign pop       = out_valid & out_ready;
  assign push      = inflight;
  assign occ       = count - {1'b0, pop} + {1'b0, inflight};
  assign addr_inc  = (ram_address == AWIDTH'(NUM_WORDS - 1))
                   ? '0 : ram_address + 1'b1;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    issue    = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept   = 1'b1;
          state_nx = (num_words == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (remaining == '0) begin
          state_nx = DRAIN;
        end else if (occ < 2'd2) begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      remaining     <= '0;
      ram_address   <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
    end else begin
      state         <= state_nx;
      inflight      <= issue;
      inflight_last <= issue && (remaining == 1);
      if (accept) begin
        remaining <= num_words;
        if (num_words != '0) begin
          ram_address <= base_addr;
        end
      end
      if (issue) begin
        ram_address <= addr_inc;
        remaining   <= remaining - 1'b1;
      end
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: out_valid gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= ram_out;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Testbench for dpram_burst_reader: RAM model, scoreboard of expected
// stream words, directed bursts with randomized data and backpressure.
module tb_dpram_burst_reader;

  localparam int AW = 11;
  localparam int NW = 2048;
  localparam int DW = 60;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_address;
  logic          ram_wren;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_out;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  dpram_burst_reader #(
    .AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done),
    .ram_address(ram_address), .ram_wren(ram_wren),
    .ram_data(ram_data), .ram_out(ram_out),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  logic [DW-1:0] mem [NW];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ram_out <= mem[ram_address];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  logic [DW:0] expq [$];
  int          issq [$];
  int hs_n, issued, done_n, vcnt;
  int first_rel, last_rel, done_rel;
  logic busy1;

  logic          pvalid, pready, plast, pbusy, prst;
  logic [DW-1:0] pdata;
  logic [AW-1:0] paddr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    int rel;
    logic [DW:0] e;
    rel = cyc - t0;
    if (!prst && pbusy && ram_address !== paddr) begin
      issq.push_back(int'(paddr));
      issued++;
      chk("outstanding_le2", 64'((issued - hs_n) <= 2), 64'd1);
    end
    if (pvalid && !pready && !prst) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'(pdata));
      chk("stall_last", 64'(out_last), 64'(plast));
    end
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("extra_word", 64'd1, 64'd0);
      end else begin
        e = expq.pop_front();
        chk("data", 64'(out_data), 64'(e[DW-1:0]));
        chk("last", 64'(out_last), 64'(e[DW]));
      end
      if (hs_n == 0) first_rel = rel;
      last_rel = rel;
      hs_n++;
    end
    if (out_valid) vcnt++;
    if (done) begin
      done_n++;
      done_rel = rel;
    end
    if (rel == 1) busy1 = busy;
    pvalid = out_valid;
    pready = out_ready;
    plast  = out_last;
    pdata  = out_data;
    pbusy  = busy;
    paddr  = ram_address;
    prst   = reset;
  endtask

  task automatic step(input logic s, input logic r, input logic rs);
    start     = s;
    out_ready = r;
    reset     = rs;
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: ready=1; 1: stall rel 4..9 then random; 2: random 75%
  // mode 3: random 75% plus a second start at rel 100
  // mode 4: ready=1, reset asserted at rel 5 (3rd word on the stream)
  task automatic run_burst(input int base, input int n, input int mode,
                           input int budget);
    int rel;
    logic r;
    logic s;
    expq.delete();
    issq.delete();
    hs_n = 0; issued = 0; done_n = 0; vcnt = 0;
    first_rel = -1; last_rel = -1; done_rel = -1; busy1 = 1'b0;
    for (int i = 0; i < n; i++)
      expq.push_back({(i == n - 1), mem[(base + i) % NW]});
    base_addr = AW'(base);
    num_words = (AW + 1)'(n);
    t0 = cyc;
    step(1'b1, 1'b1, 1'b0);
    while (done_n == 0 && (cyc - t0) < budget) begin
      rel = cyc - t0;
      s = 1'b0;
      unique case (mode)
        1: r = (rel >= 4 && rel <= 9) ? 1'b0 : 1'($urandom % 2);
        2: r = ($urandom % 4) != 0;
        3: begin
          r = ($urandom % 4) != 0;
          if (rel == 100) begin
            s = 1'b1;
            base_addr = AW'(base + 7);
            num_words = 12'd3;
          end
        end
        default: r = 1'b1;
      endcase
      if (mode == 4 && rel == 5) begin
        step(1'b0, 1'b0, 1'b1);
        return;
      end
      step(s, r, 1'b0);
    end
    if (done_n == 0) chk("timeout_done", 64'd0, 64'd1);
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_addr"}, 64'(ram_address), 64'd0);
    chk({tag, "_wren"}, 64'(ram_wren), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] pre_addr;
    int b;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    base_addr = '0; num_words = '0;
    pvalid = 0; pready = 0; plast = 0; pdata = '0;
    pbusy = 0; paddr = '0; prst = 1'b1;
    for (int i = 0; i < NW; i++)
      mem[i] = DW'({$urandom(), $urandom()});
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk_reset_outs("reset");
    step(1'b0, 1'b1, 1'b0);

    // basic burst
    for (int i = 0; i < 4; i++) mem[5 + i] = DW'(8'hA0 + i);
    run_burst(5, 4, 0, 60);
    chk("basic_first_rel", 64'(first_rel), 64'd3);
    chk("basic_last_rel", 64'(last_rel), 64'd6);
    chk("basic_done_rel", 64'(done_rel), 64'd7);
    chk("basic_busy1", 64'(busy1), 64'd1);
    chk("basic_busy_after", 64'(pbusy), 64'd0);
    chk("basic_words", 64'(hs_n), 64'd4);
    chk("basic_dones", 64'(done_n), 64'd1);

    // wrap
    run_burst(2046, 4, 0, 60);
    chk("wrap_issues", 64'(issq.size()), 64'd4);
    if (issq.size() == 4) begin
      chk("wrap_a0", 64'(issq[0]), 64'd2046);
      chk("wrap_a1", 64'(issq[1]), 64'd2047);
      chk("wrap_a2", 64'(issq[2]), 64'd0);
      chk("wrap_a3", 64'(issq[3]), 64'd1);
    end
    chk("wrap_words", 64'(hs_n), 64'd4);

    // backpressure
    b = int'($urandom_range(0, NW - 1));
    run_burst(b, 8, 1, 400);
    chk("bp_words", 64'(hs_n), 64'd8);
    chk("bp_issued", 64'(issued), 64'd8);
    chk("bp_left", 64'(expq.size()), 64'd0);

    // zero length
    pre_addr = ram_address;
    run_burst(int'($urandom_range(0, NW - 1)), 0, 0, 20);
    chk("zero_done_rel", 64'(done_rel), 64'd1);
    chk("zero_busy1", 64'(busy1), 64'd1);
    chk("zero_busy_after", 64'(pbusy), 64'd0);
    chk("zero_valid_cycles", 64'(vcnt), 64'd0);
    chk("zero_addr", 64'(ram_address), 64'(pre_addr));

    // full sweep with ignored start
    b = int'($urandom_range(0, NW - 1));
    run_burst(b, NW, 3, 8000);
    chk("sweep_words", 64'(hs_n), 64'(NW));
    chk("sweep_left", 64'(expq.size()), 64'd0);
    chk("sweep_dones", 64'(done_n), 64'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("sweep_idle", 64'(busy), 64'd0);

    // reset mid-burst
    b = int'($urandom_range(0, NW - 1));
    run_burst(b, 10, 4, 60);
    chk_reset_outs("midrst");
    chk("midrst_words", 64'(hs_n), 64'd2);
    step(1'b0, 1'b1, 1'b0);
    b = int'($urandom_range(0, NW - 1));
    run_burst(b, 2, 0, 60);
    chk("post_words", 64'(hs_n), 64'd2);
    chk("post_left", 64'(expq.size()), 64'd0);
    chk("post_dones", 64'(done_n), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_burst_reader.md
# dpram_burst_reader

Read-side client for the 2048 x 60 dual-port RAM. On a start command it issues a burst of consecutive reads on one RAM port, absorbs the RAM's one-cycle read latency, and presents the words on a valid/ready stream with a last-word marker. It sits between a RAM port (address/wren/data/out) and a downstream consumer that can apply backpressure. Its writer-side counterpart fills the RAM through the other port.

## Interface

Parameters:
- AWIDTH, 11, RAM address width
- NUM_WORDS, 2048, RAM depth; addresses wrap modulo NUM_WORDS
- DWIDTH, 60, RAM word width

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; sampled only when busy=0
- base_addr  in  AWIDTH  first read address, latched on an accepted start
- num_words  in  AWIDTH+1  burst length, 0..NUM_WORDS, latched on an accepted start
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- ram_address  out  AWIDTH  registered address to the RAM port
- ram_wren  out  1  tied 0; this block never writes
- ram_data  out  DWIDTH  tied 0
- ram_out  in  DWIDTH  RAM read data; valid one clock edge after ram_address is presented
- out_data  out  DWIDTH  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  consumer ready
- out_last  out  1  high with the final word of a burst

## Operation

- FSM states:
  - IDLE:
    - busy=0.
    - start=1 latches base_addr and num_words, then goes to ISSUE.
    - If num_words=0, goes to FIN instead.
  - ISSUE: issues reads until num_words addresses have been sent, then goes to DRAIN.
  - DRAIN: waits for the FIFO and the in-flight read to empty out through the stream, then goes to FIN.
  - FIN: done=1 for exactly one cycle, then returns to IDLE.
- Read tracking:
  - An issue register holds the current address and a remaining count.
  - A 1-bit inflight flag is set in any cycle a read is issued and is observed the next cycle.
  - The word returning on ram_out is written into a 2-entry FIFO. Each entry holds the data plus a last bit, set when the returning read was the burst's final address.
- Issue rule: issue a read in cycle t iff all of:
  - state=ISSUE
  - remaining>0
  - (fifo_count - pop_t) + inflight_t < 2, where pop_t = out_valid & out_ready
- Per issued read:
  - ram_address <= address
  - address <= (address+1) mod NUM_WORDS
  - remaining <= remaining-1
- Wrap: address NUM_WORDS-1 is followed by 0.
- Stream outputs: out_valid = FIFO not empty; out_data and out_last come from the FIFO head.
- Stream hold: while out_valid=1 and out_ready=0, out_data and out_last hold stable and no entry is lost or duplicated.
- Simultaneous FIFO push and pop: legal in any state; count unchanged.
- start while busy=1: ignored.
- Reset (any state, including mid-burst):
  - Next cycle: state IDLE, FIFO emptied, inflight cleared, returning data discarded.
  - Output values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, ram_address=0, ram_wren=0.

## Timing

- busy: high from the cycle after an accepted start through the cycle done is high, inclusive.
- Latency with out_ready=1:
  - start sampled at edge 0
  - ram_address=base_addr in cycle 1
  - ram_out valid in cycle 2
  - out_valid first high in cycle 3
- Throughput: sustained 1 word/cycle while out_ready=1; at most 2 reads outstanding (FIFO plus inflight).
- done:
  - Asserted in the cycle after the handshake of the word with out_last=1.
  - For num_words=0: done is in cycle 1 and busy is high in cycle 1 only.
- A new start is accepted in the cycle after done, i.e. when busy=0.

## Test plan

- Basic burst: RAM[5..8]=0xA0..0xA3, base_addr=5, num_words=4, out_ready=1.
  - Required: out_data 0xA0..0xA3 in cycles 3..6, out_last only in cycle 6, done in cycle 7, busy low in cycle 8.
- Wrap: base_addr=2046, num_words=4.
  - Required: ram_address sequence 2046, 2047, 0, 1; stream data matches RAM contents in that order.
- Backpressure: 8-word burst with out_ready=0 for cycles 4..9, then random toggling.
  - Required: never more than 2 reads outstanding, out_data stable while stalled, all 8 words delivered exactly once in order.
- Zero length: num_words=0.
  - Required: done in cycle 1, out_valid never asserted, ram_address unchanged.
- Full sweep plus ignored start: num_words=2048 with a start pulse mid-burst.
  - Required: 2048 words from base_addr in order, second start ignored, single done pulse.
- Reset mid-burst: assert reset at the 3rd word of a 10-word burst.
  - Required: next cycle all outputs at reset values; a following 2-word burst streams correctly with no stale data.
